transfer_unpacker: RTL and testbench
====================================

TRANSFER_UNPACKER -- requirements
Module: transfer_unpacker

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port flush  in  1  synchronous discard of all buffered words and byte state.
REQ-004 SHALL have port xfer_in  in  16  word presented from the transfer bus.
REQ-005 SHALL have port xfer_hi_first  in  1  byte order for the word being accepted: 1 = high byte first.
REQ-006 SHALL have port xfer_valid  in  1  xfer_in and xfer_hi_first are valid this cycle.
REQ-007 SHALL have port xfer_ready  out  1  block can accept a word this cycle.
REQ-008 SHALL have port main_out  out  8  byte driven toward the 8-bit main bus.
REQ-009 SHALL have port main_oe  out  1  main_out drive enable; the bus tri-state sits outside this block.
REQ-010 SHALL have port byte_valid  out  1  main_out holds a valid byte.
REQ-011 SHALL have port byte_ready  in  1  main-bus consumer takes the byte this cycle.
REQ-012 SHALL have port byte_is_hi  out  1  current main_out is bits [15:8] of its word.
REQ-013 SHALL have port word_count  out  2  number of words buffered, 0..2.

Function
REQ-014 SHALL buffer up to 2 words in a FIFO; each entry is {hi_first, word[15:0]}.
REQ-015 SHALL drive xfer_ready = (word_count < 2) and not flush; it is combinational from registered state only and does not depend on byte_ready.
REQ-016 SHALL push the entry on a cycle with xfer_valid and xfer_ready; xfer_valid while xfer_ready=0 SHALL have no effect.
REQ-017 SHALL run a byte-phase state machine with states FIRST and SECOND, applied to the FIFO head entry.
REQ-018 SHALL in FIRST output the low byte if hi_first=0, else the high byte; in SECOND output the other byte.
REQ-019 SHALL drive byte_valid = main_oe = (word_count != 0); with word_count=0, main_out = 8'h00 and byte_is_hi = 0.
REQ-020 SHALL on byte_valid and byte_ready in FIRST move to SECOND with no pop.
REQ-021 SHALL on byte_valid and byte_ready in SECOND pop the head and return to FIRST.
REQ-022 SHALL hold main_out, byte_is_hi and the state stable while byte_valid=1 and byte_ready=0.
REQ-023 Latency: a word pushed into an empty FIFO in cycle N SHALL give byte_valid=1 in cycle N+1. There is no same-cycle pass-through.
REQ-024 SHALL allow push and pop in the same cycle; the net word_count change is then 0.
REQ-025 With word_count=2, push is blocked; a pop in that cycle frees the slot from the next cycle only.
REQ-026 FIFO pointers SHALL be 1-bit and wrap modulo 2; word_count SHALL never exceed 2 or go below 0.
REQ-027 flush SHALL in the next cycle give word_count=0, state FIRST and pointers 0, and SHALL drop any push or pop in the same cycle.
REQ-028 Priority SHALL be rst > flush > push/pop.
REQ-029 byte_ready while byte_valid=0 SHALL be ignored.

Reset
REQ-030 rst=1 at a clock edge SHALL clear the FIFO, pointers and word_count to 0 and set the state to FIRST.
REQ-031 SHALL give these values during and after reset: xfer_ready=0 while rst is asserted and 1 in the first cycle after; byte_valid=0; main_oe=0; main_out=8'h00; byte_is_hi=0.
REQ-032 rst asserted mid-word (state SECOND) SHALL abandon the partial word; no byte SHALL be emitted for it after reset.

Verification
REQ-033 Push 16'hA55A with hi_first=0, byte_ready=1 -> main_out 8'h5A (byte_is_hi=0) in cycle N+1, 8'hA5 (byte_is_hi=1) in N+2, then word_count=0 and byte_valid=0.
REQ-034 Push 16'h1234 with hi_first=1 and hold byte_ready=0 for 3 cycles -> main_out stays 8'h12 and byte_is_hi stays 1; then byte_ready=1 -> 8'h34 in the following cycle.
REQ-035 Push 16'h1111, 16'h2222 and 16'h3333 on back-to-back cycles with byte_ready=0 -> word_count=2 and xfer_ready=0, and 16'h3333 is not taken; release byte_ready -> bytes 11,11,22,22 in order.
REQ-036 Hold word_count=1 in state SECOND, then push and pop in the same cycle -> word_count stays 1 and the new word's first byte appears the next cycle.
REQ-037 Assert flush during state SECOND with xfer_valid=1 -> next cycle word_count=0, byte_valid=0, and the flushed-cycle word is dropped.
REQ-038 Assert rst with word_count=2 -> next cycle all outputs are at their REQ-031 values, and a subsequent push of 16'hBEEF emits EF then BE.

Source files
------------

// File: rtl/transfer_unpacker.sv
// Two-entry word FIFO feeding an 8-bit main bus, one byte at a time.
// Each entry carries its own byte order, so mixed-order streams unpack correctly.
//
// state  | meaning
// FIRST  | presenting the first byte of the head word (low byte unless hi_first)
// SECOND | first byte taken; presenting the other byte, pop on acceptance
module transfer_unpacker (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [15:0] xfer_in,
    input  logic        xfer_hi_first,
    input  logic        xfer_valid,
    output logic        xfer_ready,
    output logic [7:0]  main_out,
    output logic        main_oe,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        byte_is_hi,
    output logic [1:0]  word_count
);

    typedef enum logic {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } phase_t;

    phase_t      state;
    phase_t      state_nxt;
    logic [16:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;
    logic        fire;
    logic        hi_sel;
    logic [16:0] head;

    assign xfer_ready = (count != 2'd2) && !flush && !rst;
    assign byte_valid = (count != 2'd0) && !rst;
    assign main_oe    = byte_valid;
    assign word_count = count;

    assign push = xfer_valid && xfer_ready;
    assign fire = byte_valid && byte_ready;
    assign pop  = fire && (state == SECOND);

    // head[16] is the entry's hi_first flag; SECOND presents the opposite half
    assign head       = mem[rd_ptr];
    assign hi_sel     = (state == FIRST) ? head[16] : !head[16];
    assign main_out   = byte_valid ? (hi_sel ? head[15:8] : head[7:0]) : 8'h00;
    assign byte_is_hi = byte_valid && hi_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = FIRST;
        end else if (fire) begin
            state_nxt = (state == FIRST) ? SECOND : FIRST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {xfer_hi_first, xfer_in};
                wr_ptr      <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_transfer_unpacker.sv
// Scoreboard bench for transfer_unpacker: directed pushes queue their expected
// bytes; a negedge monitor compares every byte the main bus accepts.
module tb_transfer_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] xfer_in;
    logic        xfer_hi_first;
    logic        xfer_valid;
    logic        xfer_ready;
    logic [7:0]  main_out;
    logic        main_oe;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_is_hi;
    logic [1:0]  word_count;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q [$];

    transfer_unpacker dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .xfer_in       (xfer_in),
        .xfer_hi_first (xfer_hi_first),
        .xfer_valid    (xfer_valid),
        .xfer_ready    (xfer_ready),
        .main_out      (main_out),
        .main_oe       (main_oe),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .byte_is_hi    (byte_is_hi),
        .word_count    (word_count)
    );

    always #5 clk = !clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // queue the two bytes a word should produce, in emission order
    task automatic expect_word(input logic [15:0] w, input logic hf);
        if (hf) begin
            exp_q.push_back({1'b1, w[15:8]});
            exp_q.push_back({1'b0, w[7:0]});
        end else begin
            exp_q.push_back({1'b0, w[7:0]});
            exp_q.push_back({1'b1, w[15:8]});
        end
    endtask

    // monitor: every accepted byte must match the scoreboard head
    always @(negedge clk) begin
        checks++;
        if (main_oe !== byte_valid) begin
            errors++;
            $display("FAIL oe_vs_valid: main_oe %0b byte_valid %0b", main_oe, byte_valid);
        end
        if (byte_valid === 1'b1 && byte_ready === 1'b1) begin
            logic [8:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: got %0h hi=%0b expected none", main_out, byte_is_hi);
            end else begin
                e = exp_q.pop_front();
                if ({byte_is_hi, main_out} !== e) begin
                    errors++;
                    $display("FAIL byte: got %0h hi=%0b expected %0h hi=%0b",
                             main_out, byte_is_hi, e[7:0], e[8]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; xfer_in = 16'h0; xfer_hi_first = 1'b0;
        xfer_valid = 1'b0; byte_ready = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_xfer_ready", xfer_ready, 0);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_main_out", main_out, 8'h00);
        chk("rst_byte_is_hi", byte_is_hi, 0);
        chk("rst_word_count", word_count, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_xfer_ready", xfer_ready, 1);

        // A55A low byte first, consumer always ready
        tick();
        byte_ready = 1'b1;
        xfer_in = 16'hA55A; xfer_hi_first = 1'b0; xfer_valid = 1'b1;
        expect_word(16'hA55A, 1'b0);
        @(negedge clk);
        chk("lat_same_cycle_bv", byte_valid, 0);
        tick();
        xfer_valid = 1'b0;
        @(negedge clk);
        chk("lat_next_cycle_bv", byte_valid, 1);
        chk("a55a_first", main_out, 8'h5A);
        tick();
        tick();
        @(negedge clk);
        chk("a55a_wc_empty", word_count, 0);
        chk("a55a_bv_empty", byte_valid, 0);
        chk("empty_main_out", main_out, 8'h00);

        // 1234 high first, stalled three cycles
        tick();
        byte_ready = 1'b0;
        xfer_in = 16'h1234; xfer_hi_first = 1'b1; xfer_valid = 1'b1;
        expect_word(16'h1234, 1'b1);
        tick();
        xfer_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_main_out", main_out, 8'h12);
            chk("stall_is_hi", byte_is_hi, 1);
            tick();
        end
        byte_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("stall_release_second", main_out, 8'h34);
        tick();
        @(negedge clk);
        chk("stall_wc_empty", word_count, 0);

        // three back-to-back pushes, third refused when full
        tick();
        byte_ready = 1'b0;
        xfer_hi_first = 1'b0; xfer_valid = 1'b1;
        xfer_in = 16'h1111; expect_word(16'h1111, 1'b0);
        tick();
        xfer_in = 16'h2222; expect_word(16'h2222, 1'b0);
        tick();
        xfer_in = 16'h3333;
        @(negedge clk);
        chk("full_xfer_ready", xfer_ready, 0);
        chk("full_wc", word_count, 2);
        tick();
        xfer_valid = 1'b0;
        @(negedge clk);
        chk("full_wc_after", word_count, 2);
        tick();
        byte_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        chk("full_drained_wc", word_count, 0);
        chk("full_queue_empty", exp_q.size(), 0);

        // push and pop in the same cycle while in SECOND
        tick();
        byte_ready = 1'b0;
        xfer_in = 16'hABCD; xfer_hi_first = 1'b0; xfer_valid = 1'b1;
        expect_word(16'hABCD, 1'b0);
        tick();
        xfer_valid = 1'b0; byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        @(negedge clk);
        chk("second_is_hi", byte_is_hi, 1);
        chk("second_wc", word_count, 1);
        tick();
        xfer_in = 16'h5678; xfer_hi_first = 1'b1; xfer_valid = 1'b1; byte_ready = 1'b1;
        expect_word(16'h5678, 1'b1);
        @(negedge clk);
        chk("pushpop_xfer_ready", xfer_ready, 1);
        tick();
        xfer_valid = 1'b0; byte_ready = 1'b0;
        @(negedge clk);
        chk("pushpop_wc", word_count, 1);
        chk("pushpop_new_first", main_out, 8'h56);
        tick();
        byte_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("pushpop_drained", word_count, 0);

        // flush in SECOND with a push offered the same cycle
        tick();
        byte_ready = 1'b0;
        xfer_in = 16'h9876; xfer_hi_first = 1'b0; xfer_valid = 1'b1;
        expect_word(16'h9876, 1'b0);
        tick();
        xfer_valid = 1'b0; byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        flush = 1'b1; xfer_in = 16'h4444; xfer_valid = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("flush_xfer_ready", xfer_ready, 0);
        tick();
        flush = 1'b0; xfer_valid = 1'b0; byte_ready = 1'b1;
        @(negedge clk);
        chk("flush_wc", word_count, 0);
        chk("flush_bv", byte_valid, 0);
        tick();
        xfer_in = 16'h0102; xfer_hi_first = 1'b0; xfer_valid = 1'b1;
        expect_word(16'h0102, 1'b0);
        tick();
        xfer_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_first", main_out, 8'h02);
        tick();
        tick();

        // reset with two words buffered, mid-word
        byte_ready = 1'b0;
        xfer_in = 16'hC0DE; xfer_hi_first = 1'b0; xfer_valid = 1'b1;
        tick();
        xfer_in = 16'hD00D; byte_ready = 1'b1;
        exp_q.push_back({1'b0, 8'hDE});
        tick();
        xfer_valid = 1'b0; byte_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_wc", word_count, 2);
        tick();
        rst = 1'b1; byte_ready = 1'b1;
        @(negedge clk);
        chk("in_rst_xfer_ready", xfer_ready, 0);
        chk("in_rst_bv", byte_valid, 0);
        chk("in_rst_main_out", main_out, 8'h00);
        chk("in_rst_is_hi", byte_is_hi, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_xfer_ready", xfer_ready, 1);
        chk("after_rst_wc", word_count, 0);
        chk("after_rst_bv", byte_valid, 0);
        chk("after_rst_main_out", main_out, 8'h00);
        tick();
        xfer_in = 16'hBEEF; xfer_hi_first = 1'b0; xfer_valid = 1'b1;
        expect_word(16'hBEEF, 1'b0);
        tick();
        xfer_valid = 1'b0;
        @(negedge clk);
        chk("beef_first", main_out, 8'hEF);
        tick();
        @(negedge clk);
        chk("beef_second", main_out, 8'hBE);
        tick();
        tick();
        @(negedge clk);
        chk("final_wc", word_count, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
